// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out serializer.
// Beat count depends on PISO_PARITY_EN (extra even-parity beat when defined).
package piso_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Serial beats needed to move one word of the given width.
   function automatic int piso_beats(input int width);
`ifdef PISO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

   localparam int BEATS = piso_beats(DEFAULT_WIDTH);

endpackage

// File: rtl/piso_serializer.sv
// Parallel word in over valid/ready, shifted out one bit per accepted serial beat.
// Optional even-parity trailer beat enabled by defining PISO_PARITY_EN.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_last
);

   localparam int WORD_BEATS = piso_beats(WIDTH);
   localparam int CNT_W      = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BEATS - 1);

   state_t                 state_reg, state_next;
   logic [WORD_BEATS-1:0]  shift_reg, shift_next, load_word;
   logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
   logic                   head_bit;
   logic                   last_beat;

   // Parity rides in the shift register as one more bit on the trailing end.
   always_comb begin
`ifdef PISO_PARITY_EN
      load_word = MSB_FIRST ? {in, ^in} : {^in, in};
`else
      load_word = in;
`endif
   end

   assign head_bit  = MSB_FIRST ? shift_reg[WORD_BEATS-1] : shift_reg[0];
   assign last_beat = (bit_cnt_reg == LAST_CNT);

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               shift_next   = load_word;
               bit_cnt_next = '0;
               state_next   = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               shift_next = MSB_FIRST ? {shift_reg[WORD_BEATS-2:0], 1'b0}
                                      : {1'b0, shift_reg[WORD_BEATS-1:1]};
               if (last_beat) begin
                  bit_cnt_next = '0;
                  state_next   = IDLE;
               end else begin
                  bit_cnt_next = bit_cnt_reg + CNT_W'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
      end
   end

   // Outputs decode registered state only; ser_ready never reaches in_ready.
   assign in_ready  = (state_reg == IDLE);
   assign ser_valid = (state_reg == SHIFT);
   assign ser_out   = ser_valid & head_bit;
   assign ser_last  = ser_valid & last_beat;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: two serializers (MSB-first and LSB-first) share stimulus.
// Honours PISO_PARITY_EN to choose the expected beat count and parity trailer.
module tb_piso_serializer;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] in = '0;
   logic         in_valid = 1'b0;
   logic         ser_ready = 1'b0;
   logic         in_ready0, ser_out0, ser_valid0, ser_last0;
   logic         in_ready1, ser_out1, ser_valid1, ser_last1;

   int checks = 0;
   int errors = 0;

   logic [3:0] mon_q[$];   // {out_msb, last_msb, out_lsb, last_lsb} per accepted beat

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready0),
      .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_ready(ser_ready), .ser_last(ser_last0)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready1),
      .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_ready(ser_ready), .ser_last(ser_last1)
   );

   always @(posedge clk) begin
      if (!reset && ser_valid0 && ser_ready)
         mon_q.push_back({ser_out0, ser_last0, ser_out1, ser_last1});
   end

   typedef struct {
      logic [3:0] word;
      logic [3:0] msb_seq;   // beats in order, first beat in bit 3
      logic [3:0] lsb_seq;
      logic       par;
   } vec_t;

   vec_t tbl[7];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: beat k of a word, from the word's bit order and its parity.
   function automatic int model_bit(input int w, input int msb, input int k);
      if (k < W) return msb ? ((w >> (W - 1 - k)) & 1) : ((w >> k) & 1);
      return $countones(w) % 2;
   endfunction

   task automatic send_word(input logic [3:0] w);
      int n = 0;
      while (!in_ready0 && n < 50) begin step(); n++; end
      check("wait_in_ready", int'(in_ready0), 1);
      in = w;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("latency_valid", int'(ser_valid0 & ser_valid1), 1);
      check("busy_in_ready", int'(in_ready0 | in_ready1), 0);
   endtask

   task automatic wait_beats(input int n, input bit rnd, output int cycles);
      cycles = 0;
      while (mon_q.size() < n && cycles < 200) begin
         ser_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         cycles++;
      end
      check("beat_budget", int'(mon_q.size() >= n), 1);
   endtask

   task automatic check_model(input string name, input logic [3:0] w);
      logic [3:0] e;
      for (int k = 0; k < NB; k++) begin
         if (mon_q.size() == 0) begin
            check({name, "_missing"}, 0, 1);
            return;
         end
         e = mon_q.pop_front();
         check({name, "_msb"}, int'(e[3]), model_bit(int'(w), 1, k));
         check({name, "_lsb"}, int'(e[1]), model_bit(int'(w), 0, k));
         check({name, "_last"}, int'({e[2], e[0]}), (k == NB - 1) ? 3 : 0);
      end
   endtask

   initial begin
      logic [3:0] e;
      logic [3:0] w;
      int cyc;
      bit exp_m, exp_l;

      tbl[0] = '{4'b1101, 4'b1101, 4'b1011, 1'b1};
      tbl[1] = '{4'b1111, 4'b1111, 4'b1111, 1'b0};
      tbl[2] = '{4'b0001, 4'b0001, 4'b1000, 1'b1};
      tbl[3] = '{4'b1100, 4'b1100, 4'b0011, 1'b0};
      tbl[4] = '{4'b1010, 4'b1010, 4'b0101, 1'b0};
      tbl[5] = '{4'b0110, 4'b0110, 4'b0110, 1'b0};
      tbl[6] = '{4'b1000, 4'b1000, 4'b0001, 1'b1};

      // Reset held two cycles
      step(); step();
      reset = 1'b0;
      check("rst_in_ready", int'({in_ready0, in_ready1}), 3);
      check("rst_ser_valid", int'({ser_valid0, ser_valid1}), 0);
      check("rst_ser_out", int'({ser_out0, ser_out1}), 0);
      check("rst_ser_last", int'({ser_last0, ser_last1}), 0);

      // Table: full-rate words against hand-written beat sequences
      ser_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send_word(tbl[i].word);
         wait_beats(NB, 1'b0, cyc);
         check("tbl_cycles", cyc, NB);
         check("tbl_in_ready_back", int'(in_ready0 & in_ready1), 1);
         check("tbl_idle_valid", int'(ser_valid0 | ser_valid1), 0);
         for (int k = 0; k < NB; k++) begin
            e = (mon_q.size() != 0) ? mon_q.pop_front() : 4'b0000;
            exp_m = (k < W) ? tbl[i].msb_seq[3 - k] : tbl[i].par;
            exp_l = (k < W) ? tbl[i].lsb_seq[3 - k] : tbl[i].par;
            check($sformatf("tbl%0d_b%0d_msb", i, k), int'(e[3]), int'(exp_m));
            check($sformatf("tbl%0d_b%0d_lsb", i, k), int'(e[1]), int'(exp_l));
            check($sformatf("tbl%0d_b%0d_last", i, k), int'({e[2], e[0]}), (k == NB - 1) ? 3 : 0);
         end
         $display("table word %0d in=%b done", i, tbl[i].word);
      end

      // Backpressure while beat 2 of 1101 is presented
      mon_q.delete();
      send_word(4'b1101);
      ser_ready = 1'b1;
      step();
      ser_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("bp_hold_out", int'(ser_out0), 1);
         check("bp_hold_last", int'(ser_last0), 0);
         check("bp_hold_valid", int'(ser_valid0), 1);
         step();
      end
      check("bp_no_extra_beat", mon_q.size(), 1);
      wait_beats(NB, 1'b0, cyc);
      check_model("bp_stream", 4'b1101);
      $display("backpressure sequence done");

      // Second word offered during SHIFT must wait for IDLE
      in = 4'b1111;
      in_valid = 1'b1;
      ser_ready = 1'b1;
      step();
      in = 4'b0001;
      wait_beats(2 * NB, 1'b0, cyc);
      in_valid = 1'b0;
      check("b2b_cycles", cyc, 2 * NB + 1);
      check_model("b2b_first", 4'b1111);
      check_model("b2b_second", 4'b0001);
      $display("back-to-back sequence done");

      // Reset in the middle of 1100
      send_word(4'b1100);
      step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_ser_valid", int'({ser_valid0, ser_valid1}), 0);
      check("abort_in_ready", int'({in_ready0, in_ready1}), 3);
      check("abort_ser_out", int'({ser_out0, ser_out1}), 0);
      check("abort_ser_last", int'({ser_last0, ser_last1}), 0);
      check("abort_beats_seen", mon_q.size(), 2);
      mon_q.delete();
      send_word(4'b1010);
      wait_beats(NB, 1'b0, cyc);
      check_model("abort_next", 4'b1010);
      $display("mid-word reset sequence done");

      // Random words under random backpressure against the model
      for (int t = 0; t < 25; t++) begin
         w = 4'($urandom_range(0, 15));
         ser_ready = 1'($urandom_range(0, 1));
         send_word(w);
         wait_beats(NB, 1'b1, cyc);
         check_model("rand", w);
         $display("random word %0d in=%b cycles=%0d", t, w, cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
